// File: rtl/demux_pkg.sv
// demux_pkg: shared types and sizes for the 4-slot TDM demultiplexer
package demux_pkg;
  typedef enum logic {IDLE, COLLECT} state_t;
  localparam int NUM_SLOTS = 4;
  localparam int SLOT_IDX_W = 2;
  localparam int ERR_CNT_W = 8;
endpackage

// File: rtl/demux_slot_ctrl.sv
// demux_slot_ctrl: frame FSM, slot counter, early-sof detection and in_ready
// ports: clk, rst_n; in_valid/in_sof/in_ready slot handshake; out_valid/out_ready
// observe the output register; slot_wr strobes staging lanes 0..2; frame_done
// marks acceptance of slot 3; frame_err is the registered early-sof pulse
module demux_slot_ctrl import demux_pkg::*; (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic                 out_valid,
  input  logic                 out_ready,
  output logic                 in_ready,
  output logic [NUM_SLOTS-2:0] slot_wr,
  output logic                 frame_done,
  output logic                 frame_err
);
  localparam logic [SLOT_IDX_W-1:0] LAST = SLOT_IDX_W'(NUM_SLOTS - 1);
  state_t state, state_n;
  logic [SLOT_IDX_W-1:0] cnt, cnt_n;
  logic [NUM_SLOTS-1:0] wr;
  logic accept, err_det;
  // only slot 3 needs a free output register; earlier slots land in staging
  assign in_ready = !(state == COLLECT && cnt == LAST && out_valid && !out_ready);
  assign accept = in_valid && in_ready;
  assign slot_wr = wr[NUM_SLOTS-2:0];
  assign frame_done = wr[NUM_SLOTS-1];
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    wr = '0;
    err_det = 1'b0;
    if (accept && in_sof) begin
      state_n = COLLECT;
      cnt_n = SLOT_IDX_W'(1);
      wr[0] = 1'b1;
      err_det = state == COLLECT;
    end else if (accept && state == COLLECT) begin
      wr[cnt] = 1'b1;
      state_n = cnt == LAST ? IDLE : COLLECT;
      // wraps back to 0 when slot 3 completes the frame
      cnt_n = cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      frame_err <= err_det;
    end
endmodule

// File: rtl/demux_4ch_tdm.sv
// demux_4ch_tdm: assembles 4-slot TDM frames and presents all lanes under valid/ready
// ports: clk, rst_n (async, active-low); in_valid/in_ready/in_data/in_sof slot input;
// out_valid/out_ready/out_data frame output (lane n = out_data[n*WIDTH +: WIDTH]);
// frame_err one-cycle early-sof pulse; err_cnt saturating error count only when
// DEMUX_ERR_CNT_EN is defined
module demux_4ch_tdm import demux_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_sof,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_SLOTS*WIDTH-1:0] out_data,
  output logic                       frame_err
`ifdef DEMUX_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0]       err_cnt
`endif
);
  logic [NUM_SLOTS-2:0][WIDTH-1:0] stage;
  logic [NUM_SLOTS-2:0] slot_wr;
  logic frame_done;
  demux_slot_ctrl u_ctrl (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_sof(in_sof),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .in_ready(in_ready),
    .slot_wr(slot_wr),
    .frame_done(frame_done),
    .frame_err(frame_err)
  );
  // slot 3 bypasses staging straight into the top lane of the output register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stage <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SLOTS - 1; i++)
        if (slot_wr[i]) stage[i] <= in_data;
      if (frame_done) begin
        out_data <= {in_data, stage};
        out_valid <= 1'b1;
      end else if (out_ready) out_valid <= 1'b0;
    end
`ifdef DEMUX_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_cnt <= '0;
    else if (frame_err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
`endif
endmodule
